ram_test_seq: RTL

- Downstream consumer of the clock-strobe generator in the RAM test build.
- Uses the divider's single-cycle strobes as pacing ticks:
  - initClk paces the memory fill phase.
  - readClk paces the readback phase.
- Fills a synchronous single-port RAM with an address-derived pattern, reads it back, compares every word, and reports pass/fail, error count and first failing address.

---
 rtl/ram_test_seq.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/ram_test_seq.sv
// rtl/ram_test_seq.sv - RAM fill/readback self-test sequencer
//
// Purpose: fills a synchronous single-port RAM with an address-derived
// pattern (addr XOR SEED), reads every word back, compares it and reports
// pass/fail, a saturating error count and the first failing address.
// Writes are paced by initTick, reads by readTick.
//
// Ports:
//   sysClk, resetN        clock (posedge) and asynchronous active-low reset
//   initTick, readTick    one-cycle pacing strobes for writes / reads
//   start                 begins a run when sampled in IDLE or DONE
//   ramAddr, ramWrData    RAM address / write data
//   ramWe, ramRe          RAM write / read enables, one cycle per access
//   ramRdData             RAM read data, valid one cycle after ramRe
//   busy, done, pass      run status
//   errCount              saturating mismatch count
//   firstErrAddr          address of the first mismatch (0 if none)
//   invPass               second (inverted-pattern) pass active
//
// Optional feature: define RAM_TEST_INVERT_EN to add a second pass using the
// inverted pattern and the invPass output.

module ram_test_seq #(
    parameter int                ADDR_W = 10,
    parameter int                DATA_W = 16,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(16'hA5C3)
) (
    input  logic              sysClk,
    input  logic              resetN,
    input  logic              initTick,
    input  logic              readTick,
    input  logic              start,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [DATA_W-1:0] ramWrData,
    output logic              ramWe,
    output logic              ramRe,
    input  logic [DATA_W-1:0] ramRdData,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       errCount,
    output logic [ADDR_W-1:0] firstErrAddr
`ifdef RAM_TEST_INVERT_EN
    ,
    output logic              invPass
`endif
);

`ifdef RAM_TEST_INVERT_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    localparam int EXT_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state;
    state_t stateNext;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addrNext;
    logic [ADDR_W-1:0] addrHold;
    logic [DATA_W-1:0] wrHold;
    logic              secondPass;
    logic              secondNext;
    logic              clearRun;

    logic              cmpValid;
    logic [ADDR_W-1:0] expAddr;
    logic              expInv;
    logic              cmpErr;
    logic [15:0]       errNext;
    logic [DATA_W-1:0] curPattern;
    logic [DATA_W-1:0] expPattern;

    // Address is zero-extended or truncated to DATA_W before the XOR.
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        logic [EXT_W-1:0] ext;
        ext = EXT_W'(a);
        return ext[DATA_W-1:0] ^ SEED;
    endfunction

    assign curPattern = pattern(addr) ^ {DATA_W{secondPass}};
    assign expPattern = pattern(expAddr) ^ {DATA_W{expInv}};

    always_ff @(posedge sysClk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        addrNext   = addr;
        secondNext = secondPass;
        clearRun   = 1'b0;
        ramWe      = 1'b0;
        ramRe      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    stateNext  = FILL;
                    addrNext   = '0;
                    secondNext = 1'b0;
                    clearRun   = 1'b1;
                end
            end
            FILL: begin
                if (initTick) begin
                    ramWe = 1'b1;
                    if (&addr) begin
                        stateNext = READ;
                        addrNext  = '0;
                    end else begin
                        addrNext = addr + 1'b1;
                    end
                end
            end
            READ: begin
                if (readTick) begin
                    ramRe = 1'b1;
                    if (&addr) begin
                        stateNext = DRAIN;
                        addrNext  = '0;
                    end else begin
                        addrNext = addr + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // The final compare happens in this cycle; then either start
                // the inverted pass or finish.
                if (INV_EN && !secondPass) begin
                    stateNext  = FILL;
                    addrNext   = '0;
                    secondNext = 1'b1;
                end else begin
                    stateNext  = DONE;
                    secondNext = 1'b0;
                end
            end
            default: begin
                stateNext = IDLE;
                addrNext  = '0;
            end
        endcase
    end

    // Address/data hold their last strobed value between accesses.
    assign ramAddr   = (ramWe || ramRe) ? addr : addrHold;
    assign ramWrData = ramWe ? curPattern : wrHold;
    assign busy      = (state == FILL) || (state == READ) || (state == DRAIN);
    assign done      = (state == DONE);

    assign cmpErr  = cmpValid && (ramRdData != expPattern);
    assign errNext = (cmpErr && (errCount != 16'hFFFF)) ? errCount + 16'd1 : errCount;

    always_ff @(posedge sysClk or negedge resetN) begin
        if (!resetN) begin
            addr         <= '0;
            addrHold     <= '0;
            wrHold       <= '0;
            secondPass   <= 1'b0;
            cmpValid     <= 1'b0;
            expAddr      <= '0;
            expInv       <= 1'b0;
            errCount     <= '0;
            firstErrAddr <= '0;
            pass         <= 1'b0;
        end else begin
            addr       <= addrNext;
            secondPass <= secondNext;
            if (ramWe || ramRe) begin
                addrHold <= addr;
            end
            if (ramWe) begin
                wrHold <= curPattern;
            end
            cmpValid <= ramRe;
            if (ramRe) begin
                expAddr <= addr;
                expInv  <= secondPass;
            end
            if (clearRun) begin
                errCount     <= '0;
                firstErrAddr <= '0;
                pass         <= 1'b0;
            end else begin
                errCount <= errNext;
                if (cmpErr && (errCount == 16'd0)) begin
                    firstErrAddr <= expAddr;
                end
                // Uses errNext so the compare completing in DRAIN is counted.
                if ((state == DRAIN) && (stateNext == DONE)) begin
                    pass <= (errNext == 16'd0);
                end
            end
        end
    end

`ifdef RAM_TEST_INVERT_EN
    assign invPass = secondPass;
`endif

endmodule
